// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte FIFOs between the CPU peripheral bus and the UART core.
// TX bytes are handed to the core one at a time over the uart_send / busy
// handshake; received bytes are captured on each receive-done rising edge.
//
// state | meaning
// IDLE  | waiting for a byte in the TX FIFO
// SEND  | uart_send held high until the core reports busy
// DRAIN | core transmitting; wait for busy to clear
module uart_fifo_bridge #(
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [7:0]                wr_data,
   input  logic                      rd_en,
   output logic [7:0]                rd_data,
   output logic                      tx_full,
   output logic                      tx_empty,
   output logic                      rx_full,
   output logic                      rx_empty,
   output logic [$clog2(TX_DEPTH):0] tx_level,
   output logic [$clog2(RX_DEPTH):0] rx_level,
   input  logic                      status_clr,
   output logic                      tx_ovf,
   output logic                      rx_ovf,
   output logic                      rx_err,
   input  logic                      tx_ie,
   input  logic                      rx_ie,
   output logic                      irq,
   output logic [7:0]                uart_txreg,
   output logic                      uart_send,
   input  logic                      uart_txbusy,
   input  logic [7:0]                uart_rxreg,
   input  logic                      uart_rxdone,
   input  logic                      uart_rxerror
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_ONE = {{TAW{1'b0}}, 1'b1};
   localparam logic [RAW:0] RX_ONE = {{RAW{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [7:0] tx_mem [TX_DEPTH];
   logic [7:0] rx_mem [RX_DEPTH];

   logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [1:0]   state_q, state_d;
   logic [7:0]   txreg_q, txreg_d;
   logic         send_q, send_d;
   logic         busy_m_q, busy_m_d, busy_s_q, busy_s_d;
   logic         done_m_q, done_m_d, done_s_q, done_s_d, done_p_q, done_p_d;
   logic         err_m_q, err_m_d, err_s_q, err_s_d;
   logic         tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, rx_err_q, rx_err_d;
   logic         irq_q, irq_d;
   logic         tx_push, tx_pop, rx_push, rx_pop, done_rise;

   assign tx_empty   = (tx_wp_q == tx_rp_q);
   assign tx_full    = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
   assign rx_empty   = (rx_wp_q == rx_rp_q);
   assign rx_full    = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
   assign tx_level   = tx_wp_q - tx_rp_q;
   assign rx_level   = rx_wp_q - rx_rp_q;
   assign rd_data    = rx_empty ? 8'h00 : rx_mem[rx_rp_q[RAW-1:0]];
   assign tx_ovf     = tx_ovf_q;
   assign rx_ovf     = rx_ovf_q;
   assign rx_err     = rx_err_q;
   assign irq        = irq_q;
   assign uart_txreg = txreg_q;
   assign uart_send  = send_q;

   // TX handshake FSM: load head, raise send until the core goes busy, then wait it out
   always_comb begin
      state_d = state_q;
      txreg_d = txreg_q;
      send_d  = send_q;
      tx_pop  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!tx_empty) begin
               tx_pop  = 1'b1;
               txreg_d = tx_mem[tx_rp_q[TAW-1:0]];
               send_d  = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (busy_s_q) begin
               send_d  = 1'b0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!busy_s_q) state_d = ST_IDLE;
         end
         default: begin
            send_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Synchronizers, FIFO pointers, sticky status and interrupt next-state
   always_comb begin
      busy_m_d  = uart_txbusy;
      busy_s_d  = busy_m_q;
      done_m_d  = uart_rxdone;
      done_s_d  = done_m_q;
      done_p_d  = done_s_q;
      err_m_d   = uart_rxerror;
      err_s_d   = err_m_q;
      done_rise = done_s_q & ~done_p_q;

      tx_push = wr_en & ~tx_full;
      rx_pop  = rd_en & ~rx_empty;
      // a pop in the same cycle frees the slot, so a full RX FIFO still accepts
      rx_push = done_rise & ~err_s_q & (~rx_full | rx_pop);

      tx_wp_d = tx_push ? tx_wp_q + TX_ONE : tx_wp_q;
      tx_rp_d = tx_pop  ? tx_rp_q + TX_ONE : tx_rp_q;
      rx_wp_d = rx_push ? rx_wp_q + RX_ONE : rx_wp_q;
      rx_rp_d = rx_pop  ? rx_rp_q + RX_ONE : rx_rp_q;

      tx_ovf_d = (wr_en & tx_full) | (tx_ovf_q & ~status_clr);
      rx_ovf_d = (done_rise & ~err_s_q & rx_full & ~rx_pop) | (rx_ovf_q & ~status_clr);
      rx_err_d = (done_rise & err_s_q) | (rx_err_q & ~status_clr);

      irq_d = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & (state_q == ST_IDLE))
            | rx_ovf_q | rx_err_q | tx_ovf_q;
   end

   // FIFO storage, deliberately left unreset
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= wr_data;
      if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= uart_rxreg;
   end

   // Control and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         state_q  <= ST_IDLE;
         txreg_q  <= 8'h00;
         send_q   <= 1'b0;
         busy_m_q <= 1'b0;
         busy_s_q <= 1'b0;
         done_m_q <= 1'b0;
         done_s_q <= 1'b0;
         done_p_q <= 1'b0;
         err_m_q  <= 1'b0;
         err_s_q  <= 1'b0;
         tx_ovf_q <= 1'b0;
         rx_ovf_q <= 1'b0;
         rx_err_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         state_q  <= state_d;
         txreg_q  <= txreg_d;
         send_q   <= send_d;
         busy_m_q <= busy_m_d;
         busy_s_q <= busy_s_d;
         done_m_q <= done_m_d;
         done_s_q <= done_s_d;
         done_p_q <= done_p_d;
         err_m_q  <= err_m_d;
         err_s_q  <= err_s_d;
         tx_ovf_q <= tx_ovf_d;
         rx_ovf_q <= rx_ovf_d;
         rx_err_q <= rx_err_d;
         irq_q    <= irq_d;
      end
   end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: TX bytes are scoreboarded against each uart_send
// rising edge, RX bytes against rd_data at each read.
module tb_uart_fifo_bridge;
   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en, status_clr, tx_ie, rx_ie;
   logic [7:0] wr_data, rd_data, uart_txreg, uart_rxreg;
   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic [4:0] tx_level, rx_level;
   logic       tx_ovf, rx_ovf, rx_err, irq, uart_send;
   logic       uart_txbusy, uart_rxdone, uart_rxerror;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] tx_exp [$];
   logic [7:0] rx_exp [$];
   logic [7:0] mon_exp;
   logic       send_prev = 1'b0;

   uart_fifo_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .tx_full(tx_full), .tx_empty(tx_empty),
      .rx_full(rx_full), .rx_empty(rx_empty), .tx_level(tx_level),
      .rx_level(rx_level), .status_clr(status_clr), .tx_ovf(tx_ovf),
      .rx_ovf(rx_ovf), .rx_err(rx_err), .tx_ie(tx_ie), .rx_ie(rx_ie), .irq(irq),
      .uart_txreg(uart_txreg), .uart_send(uart_send), .uart_txbusy(uart_txbusy),
      .uart_rxreg(uart_rxreg), .uart_rxdone(uart_rxdone), .uart_rxerror(uart_rxerror)
   );

   always #5 clk = ~clk;

   // TX scoreboard: every send rising edge must present the next queued byte
   always @(negedge clk) begin
      if (rst) begin
         send_prev = 1'b0;
      end else begin
         if (uart_send && !send_prev) begin
            checks++;
            if (tx_exp.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected_send got=%02h exp=none", uart_txreg);
            end else begin
               mon_exp = tx_exp.pop_front();
               if (uart_txreg !== mon_exp) begin
                  errors++;
                  $display("FAIL tx_byte_order got=%02h exp=%02h", uart_txreg, mon_exp);
               end
            end
         end
         send_prev = uart_send;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rx_event(input logic [7:0] b, input logic e);
      uart_rxreg   = b;
      uart_rxerror = e;
      uart_rxdone  = 1'b1;
      repeat (3) tick();
      uart_rxdone  = 1'b0;
      uart_rxerror = 1'b0;
      repeat (3) tick();
   endtask

   // Core model for one byte: release busy, wait for send, go busy 4 cycles later
   task automatic serve_byte(output bit ok);
      ok = 1'b0;
      uart_txbusy = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (uart_send) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) return;
      repeat (4) tick();
      uart_txbusy = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!uart_send) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      repeat (2) tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; status_clr = 1'b0;
      tx_ie = 1'b0; rx_ie = 1'b0; uart_txbusy = 1'b0; uart_rxreg = 8'h00;
      uart_rxdone = 1'b0; uart_rxerror = 1'b0;
      repeat (3) tick();
      checks++; if ({tx_empty, rx_empty} !== 2'b11) begin errors++; $display("FAIL reset_empty got=%b exp=11", {tx_empty, rx_empty}); end
      checks++; if ({tx_full, rx_full, tx_ovf, rx_ovf, rx_err, irq, uart_send} !== 7'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000000", {tx_full, rx_full, tx_ovf, rx_ovf, rx_err, irq, uart_send}); end
      checks++; if ({tx_level, rx_level, rd_data, uart_txreg} !== 26'h0) begin errors++; $display("FAIL reset_values got=%h exp=0", {tx_level, rx_level, rd_data, uart_txreg}); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single_tx;
      wr_en = 1'b1; wr_data = 8'hA5; tx_exp.push_back(8'hA5);
      tick();
      wr_en = 1'b0;
      checks++; if (tx_empty !== 1'b0 || tx_level !== 5'd1) begin errors++; $display("FAIL tx_after_write got=empty%b/lvl%0d exp=empty0/lvl1", tx_empty, tx_level); end
      tick();
      checks++; if (uart_send !== 1'b1 || uart_txreg !== 8'hA5) begin errors++; $display("FAIL tx_load got=send%b/%02h exp=send1/a5", uart_send, uart_txreg); end
      checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL tx_level_after_load got=%0d exp=0", tx_level); end
      repeat (4) tick();
      uart_txbusy = 1'b1;
      repeat (2) tick();
      checks++; if (uart_send !== 1'b1) begin errors++; $display("FAIL send_held_before_busy got=%b exp=1", uart_send); end
      tick();
      checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL send_fall_3_after_busy got=%b exp=0", uart_send); end
      repeat (97) tick();
      uart_txbusy = 1'b0;
      tx_ie = 1'b1;
      repeat (3) tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_idle got=%b exp=0", irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle_empty got=%b exp=1", irq); end
      checks++; if (uart_txreg !== 8'hA5) begin errors++; $display("FAIL txreg_stable got=%02h exp=a5", uart_txreg); end
      tx_ie = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_tx_burst;
      bit ok;
      uart_txbusy = 1'b1;
      repeat (3) tick();
      for (int i = 0; i <= 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i); tx_exp.push_back(8'(i));
         tick();
      end
      wr_en = 1'b0;
      checks++; if (tx_full !== 1'b1 || tx_level !== 5'd16 || tx_ovf !== 1'b0) begin errors++; $display("FAIL tx_burst_fill got=full%b/lvl%0d/ovf%b exp=full1/lvl16/ovf0", tx_full, tx_level, tx_ovf); end
      wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      checks++; if (tx_ovf !== 1'b1 || tx_level !== 5'd16) begin errors++; $display("FAIL tx_ovf_set got=ovf%b/lvl%0d exp=ovf1/lvl16", tx_ovf, tx_level); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_ovf got=%b exp=1", irq); end
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      checks++; if (tx_ovf !== 1'b0) begin errors++; $display("FAIL tx_ovf_clear got=%b exp=0", tx_ovf); end
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear got=%b exp=0", irq); end
      for (int i = 0; i < 16; i++) begin
         serve_byte(ok);
         checks++; if (!ok) begin errors++; $display("FAIL tx_handshake_timeout got=byte%0d exp=handshake", i + 1); end
      end
      uart_txbusy = 1'b0;
      repeat (5) tick();
      checks++; if (tx_exp.size() != 0 || tx_empty !== 1'b1) begin errors++; $display("FAIL tx_burst_drained got=left%0d/empty%b exp=left0/empty1", tx_exp.size(), tx_empty); end
   endtask

   task automatic test_rx_capture;
      logic [7:0] e;
      uart_rxreg = 8'h3C; uart_rxdone = 1'b1; rx_exp.push_back(8'h3C);
      repeat (2) tick();
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_early_push got=empty%b exp=1", rx_empty); end
      tick();
      checks++; if (rx_empty !== 1'b0 || rd_data !== 8'h3C) begin errors++; $display("FAIL rx_capture_timing got=empty%b/%02h exp=empty0/3c", rx_empty, rd_data); end
      uart_rxdone = 1'b0;
      repeat (3) tick();
      rx_event(8'hC3, 1'b0); rx_exp.push_back(8'hC3);
      checks++; if (rx_level !== 5'd2) begin errors++; $display("FAIL rx_level_two got=%0d exp=2", rx_level); end
      rx_ie = 1'b1;
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx_data got=%b exp=1", irq); end
      rx_ie = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = rx_exp.pop_front();
         checks++; if (rd_data !== e) begin errors++; $display("FAIL rx_drain got=%02h exp=%02h", rd_data, e); end
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      checks++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin errors++; $display("FAIL rx_empty_after_drain got=empty%b/%02h exp=empty1/00", rx_empty, rd_data); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      checks++; if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin errors++; $display("FAIL rx_read_when_empty got=lvl%0d exp=lvl0", rx_level); end
   endtask

   task automatic test_rx_overrun;
      logic [7:0] b;
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i < 16) rx_exp.push_back(b);
         rx_event(b, 1'b0);
      end
      checks++; if (rx_level !== 5'd16 || rx_full !== 1'b1 || rx_ovf !== 1'b1) begin errors++; $display("FAIL rx_overrun got=lvl%0d/full%b/ovf%b exp=lvl16/full1/ovf1", rx_level, rx_full, rx_ovf); end
      rx_event(8'h99, 1'b1);
      checks++; if (rx_err !== 1'b1 || rx_level !== 5'd16) begin errors++; $display("FAIL rx_error got=err%b/lvl%0d exp=err1/lvl16", rx_err, rx_level); end
      status_clr = 1'b1; tick(); status_clr = 1'b0;
      checks++; if (rx_ovf !== 1'b0 || rx_err !== 1'b0) begin errors++; $display("FAIL rx_status_clear got=ovf%b/err%b exp=0/0", rx_ovf, rx_err); end
      repeat (2) tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_rx_cleared got=%b exp=0", irq); end
   endtask

   task automatic test_simultaneous;
      logic [7:0] e;
      uart_rxreg = 8'h5E; uart_rxdone = 1'b1;
      repeat (2) tick();
      e = rx_exp.pop_front();
      checks++; if (rd_data !== e) begin errors++; $display("FAIL rx_head_full got=%02h exp=%02h", rd_data, e); end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0; uart_rxdone = 1'b0; rx_exp.push_back(8'h5E);
      repeat (3) tick();
      checks++; if (rx_level !== 5'd16 || rx_ovf !== 1'b0) begin errors++; $display("FAIL rx_push_pop_full got=lvl%0d/ovf%b exp=lvl16/ovf0", rx_level, rx_ovf); end
      for (int i = 0; i < 16; i++) begin
         e = rx_exp.pop_front();
         checks++; if (rd_data !== e) begin errors++; $display("FAIL rx_order got=%02h exp=%02h idx=%0d", rd_data, e, i); end
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_empty_final got=%b exp=1", rx_empty); end
   endtask

   task automatic test_reset_mid_send;
      rx_event(8'h42, 1'b0);
      wr_en = 1'b1; wr_data = 8'h5A; tx_exp.push_back(8'h5A);
      tick();
      wr_data = 8'h77; tx_exp.push_back(8'h77);
      tick();
      wr_en = 1'b0;
      checks++; if (uart_send !== 1'b1 || tx_level !== 5'd1 || rx_level !== 5'd1) begin errors++; $display("FAIL pre_reset_state got=send%b/tx%0d/rx%0d exp=send1/tx1/rx1", uart_send, tx_level, rx_level); end
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++; if (uart_send !== 1'b0) begin errors++; $display("FAIL reset_drops_send got=%b exp=0", uart_send); end
      checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1 || tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL reset_flush got=txe%b/rxe%b exp=1/1", tx_empty, rx_empty); end
      tx_exp.delete();
      tick();
      rst = 1'b0;
      repeat (2) tick();
      checks++; if (irq !== 1'b0 || uart_send !== 1'b0) begin errors++; $display("FAIL post_reset_quiet got=irq%b/send%b exp=0/0", irq, uart_send); end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_tx_burst();
      test_rx_capture();
      test_rx_overrun();
      test_simultaneous();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
